// File: rtl/calc_pkg.sv
// calc_pkg: shared width, opcodes, FSM states and MUL latency for the calculator sequencer.
package calc_pkg;
    localparam int WIDTH      = 16;
    localparam int MUL_CYCLES = 16;
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;
    typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;
endpackage

// File: rtl/calc_seq_ctrl_adder.sv
// carry_select_adder: 16-bit carry-select adder, four 4-bit blocks each precomputing both carry-in cases.
module carry_select_adder
    import calc_pkg::*;
(
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             c_in,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);
    logic [WIDTH/4:0] c;
    assign c[0]  = c_in;
    assign c_out = c[WIDTH/4];
    for (genvar g = 0; g < WIDTH/4; g++) begin : blk
        logic [4:0] s0, s1;
        assign s0 = {1'b0, x[4*g +: 4]} + {1'b0, y[4*g +: 4]};
        assign s1 = s0 + 5'd1;
        assign sum[4*g +: 4] = c[g] ? s1[3:0] : s0[3:0];
        assign c[g+1] = c[g] ? s1[4] : s0[4];
    end
endmodule

// File: rtl/calc_seq_ctrl.sv
// calc_seq_ctrl: time-shares one carry-select adder across ADD, SUB and 16-cycle shift-and-add MUL.
module calc_seq_ctrl
    import calc_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             err
);
    localparam logic [3:0] LAST = 4'(MUL_CYCLES - 1);
    state_t state, state_n;
    logic [WIDTH-1:0] a_r, b_r, acc, m, q, x, y, sum;
    logic [1:0] op_r;
    logic [3:0] cnt;
    logic m_lost, c_in, c_out, sub;
    assign busy = state != IDLE;
    assign done = state == DONE;
    assign sub  = op_r == OP_SUB;
    // MUL steers acc+m into the adder; otherwise the latched operands (b inverted for SUB)
    assign x    = state == MUL ? acc : a_r;
    assign y    = state == MUL ? m : (sub ? ~b_r : b_r);
    assign c_in = state != MUL && sub;
    carry_select_adder u_adder (.x(x), .y(y), .c_in(c_in), .sum(sum), .c_out(c_out));
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (start) state_n = op == OP_MUL ? MUL : (op == OP_RSVD ? DONE : EXEC);
            EXEC: state_n = DONE;
            MUL:  state_n = cnt == LAST ? DONE : MUL;
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {a_r, b_r, acc, m, q, result} <= '0;
            {op_r, cnt, m_lost, carry_out, overflow, err} <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    a_r <= a;
                    b_r <= b;
                    op_r <= op;
                    acc <= '0;
                    m <= a;
                    q <= b;
                    cnt <= '0;
                    m_lost <= 1'b0;
                    result <= '0;
                    carry_out <= 1'b0;
                    overflow <= 1'b0;
                    err <= op == OP_RSVD;
                end
                EXEC: begin
                    result <= sum;
                    carry_out <= c_out;
                    // y already carries ~b for SUB, so one same-sign test covers both ops
                    overflow <= (x[WIDTH-1] == y[WIDTH-1]) && (sum[WIDTH-1] != x[WIDTH-1]);
                end
                MUL: begin
                    if (q[0]) begin
                        acc <= sum;
                        overflow <= overflow | c_out | m_lost;
                    end
                    m <= m << 1;
                    m_lost <= m_lost | m[WIDTH-1];
                    q <= q >> 1;
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST) result <= q[0] ? sum : acc;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_calc_seq_ctrl.sv
// tb_calc_seq_ctrl: directed commands push expected results; a monitor checks each done pulse.
module tb_calc_seq_ctrl;
    typedef struct {
        logic [15:0] res;
        logic        c, o, e;
        int          cyc;
    } exp_t;
    logic clk = 0, rst = 1, start = 0;
    logic [1:0] op = 0;
    logic [15:0] a = 0, b = 0;
    logic busy, done, carry_out, overflow, err;
    logic [15:0] result;
    int cyc = 0, tests = 0, fails = 0;
    exp_t sb[$];

    calc_seq_ctrl dut (.clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .carry_out(carry_out),
        .overflow(overflow), .err(err));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string n, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", n, act, exp, cyc);
        end
    endtask

    always @(negedge clk) if (!rst && done) begin
        if (sb.size() == 0) chk("unexpected_done", 1, 0);
        else begin
            exp_t e;
            e = sb.pop_front();
            chk("done_cycle", cyc, e.cyc);
            chk("result", int'(result), int'(e.res));
            chk("carry_out", int'(carry_out), int'(e.c));
            chk("overflow", int'(overflow), int'(e.o));
            chk("err", int'(err), int'(e.e));
        end
    end

    task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                         input logic [15:0] r, input logic c, input logic ov, input logic e, input int lat);
        start = 1; op = o; a = x; b = y;
        sb.push_back('{r, c, ov, e, cyc + lat});
        @(negedge clk);
        start = 0; a = 16'hDEAD; b = 16'hBEEF;
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 60; k++) begin
            if (sb.size() == 0 && !busy) break;
            @(negedge clk);
        end
        if (k == 60) begin
            chk("timeout", 1, 0);
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        int t0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'({carry_out, overflow, err}), 0);
        rst = 0;
        @(negedge clk);
        issue(2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1, 0, 0, 2); wait_idle();
        issue(2'b01, 16'h0005, 16'h0007, 16'hFFFE, 0, 0, 0, 2); wait_idle();
        issue(2'b01, 16'h8000, 16'h0001, 16'h7FFF, 1, 1, 0, 2); wait_idle();
        issue(2'b10, 16'h00FF, 16'h0101, 16'hFFFF, 0, 0, 0, 17); wait_idle();
        issue(2'b10, 16'h0100, 16'h0100, 16'h0000, 0, 1, 0, 17); wait_idle();
        issue(2'b11, 16'h1234, 16'h5678, 16'h0000, 0, 0, 1, 1); wait_idle();
        issue(2'b00, 16'h0002, 16'h0003, 16'h0005, 0, 0, 0, 2); wait_idle();
        // start held high across a MUL: second accept only at T+18, with the new operands
        t0 = cyc;
        start = 1; op = 2'b10; a = 16'h0003; b = 16'h0005;
        sb.push_back('{16'd15, 0, 0, 0, t0 + 17});
        sb.push_back('{16'd14, 0, 0, 0, t0 + 35});
        repeat (5) @(negedge clk);
        a = 16'h0007; b = 16'h0002;
        repeat (12) @(negedge clk);
        chk("hold_busy_at_done", int'(busy), 1);
        @(negedge clk);
        chk("hold_idle_T18", int'(busy), 0);
        @(negedge clk);
        start = 0; a = 16'hAAAA; b = 16'h5555;
        chk("hold_busy_T19", int'(busy), 1);
        wait_idle();
        // reset mid-MUL at cnt=8: no done, outputs cleared immediately
        t0 = cyc;
        issue(2'b10, 16'h0011, 16'h0022, 16'h0242, 0, 0, 0, 17);
        repeat (8) @(negedge clk);
        rst = 1;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_outputs", int'({result, carry_out, overflow, err}), 0);
        sb.delete();
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        issue(2'b00, 16'h1234, 16'h1111, 16'h2345, 0, 0, 0, 2); wait_idle();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/calc_seq_ctrl.md
# calc_seq_ctrl

Sequencing controller for the calculator's arithmetic unit. It owns one instance of the 16-bit carry-select adder and time-shares it to execute ADD, SUB and MUL commands. MUL is done by iterative shift-and-add over 16 cycles. The block sits between the calculator's operand/opcode front end and the result display register, with a start/busy/done handshake.

## Interface
- WIDTH, 16, operand/result width; 16 is the only legal value, matching the adder.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  command request; sampled only in IDLE.
- op  in  2  00 ADD, 01 SUB, 10 MUL, 11 reserved (illegal).
- a  in  16  operand A (minuend / multiplicand).
- b  in  16  operand B (subtrahend / multiplier).
- busy  out  1  high from the cycle after accept through the done cycle.
- done  out  1  one-cycle pulse; result flags valid in that cycle.
- result  out  16  registered result; held until the next accept.
- carry_out  out  1  ADD: adder carry; SUB: 1 = no borrow; MUL: 0.
- overflow  out  1  ADD/SUB: signed overflow; MUL: unsigned product ≥ 2^16.
- err  out  1  set with done for an illegal op.

## Operation
- States: IDLE, EXEC, MUL, DONE.
- IDLE: on start=1, latch a, b, op and clear result, carry_out, overflow, err.
  - ADD/SUB → EXEC.
  - MUL → MUL with acc=0, m=a, q=b, cnt=0, m_lost=0.
  - op=11 → DONE with err=1, result=0.
- EXEC (1 cycle): drive the adder and register its outputs, then → DONE.
  - ADD: adder a, b, c_in=0; overflow = (a15==b15) & (sum15!=a15).
  - SUB: adder a, ~b, c_in=1; overflow = (a15!=b15) & (sum15!=a15).
- MUL (16 cycles, cnt 0..15): each cycle, adder inputs are acc and m with c_in=0.
  - If q[0]=1: acc ← sum; overflow |= adder carry | m_lost.
  - Then m ← m<<1, m_lost |= m[15] (pre-shift value), q ← q>>1.
  - At cnt=15 → DONE with result=acc, carry_out=0.
  - Fixed latency: no early termination when q reaches 0.
- DONE (1 cycle): done=1, busy=1, then → IDLE.
- start while busy, including the DONE cycle, is ignored and not queued.
- Operands may change after accept without affecting the result.
- Reset in any state: immediately → IDLE, all outputs 0. An aborted command never produces done.

## Timing
- Reset value of every output is 0.
- Accept cycle T is the IDLE cycle with start=1. busy rises at T+1.
- done timing after accept:
  - ADD/SUB: done at T+2.
  - MUL: done at T+17.
  - Illegal op: done at T+1.
- busy falls the cycle after done, so the next accept is possible at done+1.
- result, carry_out, overflow and err are stable from the done cycle until the next accept.
- The adder is combinational. Its result is registered in the same cycle; there is no adder pipeline stage.

## Structure
- Package calc_pkg holds:
  - WIDTH=16.
  - op encodings OP_ADD/OP_SUB/OP_MUL/OP_RSVD.
  - state enum IDLE/EXEC/MUL/DONE.
  - MUL_CYCLES=16.
- Exactly one sub-module: the existing carry_select adder, instantiated once; its input mux is owned by this block.
- The FSM, operand registers, shift registers, the 4-bit cycle counter and the flag logic live in calc_seq_ctrl.

## Test plan
- ADD a=0xFFFF b=0x0001 → done at T+2, result=0x0000, carry_out=1, overflow=0, err=0.
- SUB a=0x0005 b=0x0007 → result=0xFFFE, carry_out=0, overflow=0. SUB a=0x8000 b=0x0001 → result=0x7FFF, carry_out=1, overflow=1.
- MUL a=0x00FF b=0x0101 → done at T+17, result=0xFFFF, overflow=0. MUL a=0x0100 b=0x0100 → result=0x0000, overflow=1.
- op=11 → done at T+1, err=1, result=0. A following ADD 0x0002+0x0003 → result 0x0005, err=0.
- Hold start=1 continuously with MUL: accepts only at T and at T+18. No done between them except at T+17. Operand changes during busy do not alter the result.
- Assert rst at MUL cycle cnt=8 → all outputs 0 in the same cycle, no done pulse. The next ADD 0x1234+0x1111 → 0x2345 at done.
